ppfifo_write_arbiter: RTL and testbench

//  Shares one Ping Pong FIFO write port between NUM_REQ packet writers (AXI-stream adapters, register writers).

---
 rtl/ppfifo_write_arbiter_if.sv | 28 ++
 rtl/ppfifo_write_arbiter.sv | 116 +++++++++++
 tb/tb_ppfifo_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppfifo_write_arbiter_if.sv
// Requester and ping-pong FIFO write-side bundle for ppfifo_write_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ppfifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            stb;
  logic [NUM_REQ*DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            done;
  logic [23:0]                   space;
  logic [1:0]                    ppfifo_rdy;
  logic [1:0]                    ppfifo_act;
  logic [23:0]                   ppfifo_size;
  logic                          ppfifo_stb;
  logic [DATA_WIDTH-1:0]         ppfifo_data;

  modport slave (
    input  req, stb, data, done, ppfifo_rdy, ppfifo_size,
    output gnt, space, ppfifo_act, ppfifo_stb, ppfifo_data
  );

  modport master (
    output req, stb, data, done, ppfifo_rdy, ppfifo_size,
    input  gnt, space, ppfifo_act, ppfifo_stb, ppfifo_data
  );
endinterface

// File: rtl/ppfifo_write_arbiter.sv
// Round-robin sharing of one ping-pong FIFO write port among NUM_REQ packet writers.
// Optional idle-grant watchdog enabled by defining PPFIFO_ARB_TIMEOUT_EN.
module ppfifo_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  ppfifo_write_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       winner, rr_ptr, pick_idx;
  logic [23:0]            count, count_n, size_q;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   grant_go, write_go, timeout_hit;

  // First asserted request at or after ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick_idx = rr_pick(bus.req, rr_ptr);
  assign win_data = bus.data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign count_n  = count + {23'd0, write_go};

`ifdef PPFIFO_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == GRANT) && !write_go &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != GRANT || write_go) idle_cnt <= '0;
    else                                   idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_go = 1'b0;
    write_go = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req && |bus.ppfifo_rdy && bus.ppfifo_act == 2'b00) begin
          grant_go = 1'b1;
          state_n  = GRANT;
        end
      end
      GRANT: begin
        write_go = bus.stb[winner] && (count < size_q);
        // A word strobed alongside done still lands before the release.
        if (bus.done[winner] || !bus.req[winner] || count_n >= size_q || timeout_hit)
          state_n = RELEASE;
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- write/grant stage: registered outputs, one-cycle write latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt         <= '0;
      bus.ppfifo_act  <= 2'b00;
      bus.ppfifo_stb  <= 1'b0;
      bus.ppfifo_data <= '0;
      bus.space       <= '0;
      count           <= '0;
      size_q          <= '0;
      winner          <= '0;
      rr_ptr          <= '0;
    end else begin
      bus.ppfifo_stb <= write_go;
      if (write_go) begin
        bus.ppfifo_data <= win_data;
        count           <= count_n;
        bus.space       <= bus.space - 24'd1;
      end
      if (grant_go) begin
        winner         <= pick_idx;
        bus.gnt        <= NUM_REQ'(1) << pick_idx;
        bus.ppfifo_act <= bus.ppfifo_rdy[0] ? 2'b01 : 2'b10;
        count          <= '0;
        size_q         <= bus.ppfifo_size;
        bus.space      <= bus.ppfifo_size;
      end
      if (state == RELEASE) begin
        bus.ppfifo_act <= 2'b00;
        bus.gnt        <= '0;
        bus.space      <= '0;
        rr_ptr         <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppfifo_write_arbiter.sv
// Randomized bench for ppfifo_write_arbiter with a round-robin/packet reference model.
module tb_ppfifo_write_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
`ifdef PPFIFO_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppfifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  ppfifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_writes = 0;
  int          pkt_words = 0;
  int          ptr = 0;
  logic [23:0] pkt_size = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NR-1:0] p, input int from);
    for (int off = 0; off < NR; off++)
      if (p[(from + off) % NR]) return (from + off) % NR;
    return 0;
  endfunction

  // Every FIFO write must be the next expected word, with space = size - words so far.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt == '0) pkt_words = 0;
      else check("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
      if (bus.ppfifo_stb) begin
        n_writes++;
        pkt_words++;
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("write_data", 64'(bus.ppfifo_data), 64'(mon_e));
          check("space", 64'(bus.space), 64'(pkt_size - 24'(pkt_words)));
        end
      end
    end
  end

  task automatic wait_grant(input int exp_w, input int sz, output int cyc, output bit ok);
    logic [1:0] exp_act;
    exp_act  = bus.ppfifo_rdy[0] ? 2'b01 : 2'b10;
    pkt_size = 24'(sz);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.gnt == '0 && cyc < 10);
    ok = (bus.gnt != '0);
    check("grant_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("gnt_winner", 64'(bus.gnt), 64'(NR'(1) << exp_w));
      check("act_half", 64'(bus.ppfifo_act), 64'(exp_act));
      check("space_at_grant", 64'(bus.space), 64'(sz));
    end
  endtask

  // Drive the granted requester; words beyond the buffer size are never expected.
  task automatic run_packet(input int w, input int sz, input int len, input int mode,
                            input bit seq, output int issued);
    int  i = 0;
    int  guard = 0;
    bit  done_sent = 1'b0;
    logic [DW-1:0] word;
    while (bus.gnt != '0 && guard < 300) begin
      bus.stb  = '0;
      bus.done = '0;
      for (int k = 0; k < NR; k++) begin
        if (k != w && !seq && $urandom_range(0, 2) == 0) begin
          bus.stb[k] = 1'b1;
          bus.data[k*DW +: DW] = {16'hDEAD, 16'($urandom)};
        end
      end
      if (i < len && (seq || $urandom_range(0, 2) != 0)) begin
        word = seq ? DW'(i) : DW'($urandom);
        bus.stb[w] = 1'b1;
        bus.data[w*DW +: DW] = word;
        if (i < sz) exp_q.push_back(word);
        i++;
        if (i == len && mode == 0 && (seq || $urandom_range(0, 1) == 1)) begin
          bus.done[w] = 1'b1;
          done_sent = 1'b1;
        end
      end else if (i == len) begin
        if (mode == 0 && !done_sent) begin
          bus.done[w] = 1'b1;
          done_sent = 1'b1;
        end else if (mode == 1) begin
          bus.req[w] = 1'b0;
        end
      end
      tick();
      guard++;
    end
    bus.stb  = '0;
    bus.done = '0;
    issued = i;
    check("gnt_released", 64'(bus.gnt), 64'd0);
    check("act_released", 64'(bus.ppfifo_act), 64'd0);
    check("space_released", 64'(bus.space), 64'd0);
  endtask

  task automatic run_round(input logic [NR-1:0] mask);
    logic [NR-1:0] pending;
    int w, sz, len, md, cyc, iss;
    bit ok;
    pending = mask;
    bus.req = mask;
    while (pending != '0) begin
      w  = model_pick(pending, ptr);
      sz = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      bus.ppfifo_size = 24'(sz);
      case ($urandom_range(0, 2))
        0:       bus.ppfifo_rdy = 2'b01;
        1:       bus.ppfifo_rdy = 2'b10;
        default: bus.ppfifo_rdy = 2'b11;
      endcase
      wait_grant(w, sz, cyc, ok);
      if (!ok) begin
        bus.req = '0;
        break;
      end
      len = $urandom_range(0, sz + 2);
      md  = $urandom_range(0, 1);
      run_packet(w, sz, len, md, 1'b0, iss);
      bus.req[w] = 1'b0;
      pending[w] = 1'b0;
      ptr = (w + 1) % NR;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.stb = '0;
    bus.done = '0;
    repeat (2) tick();
    rst = 1'b0;
    ptr = 0;
  endtask

  initial begin
    int cyc, iss, wr0;
    bit ok;
    bus.req = '0;
    bus.stb = '0;
    bus.done = '0;
    bus.data = '0;
    bus.ppfifo_rdy = 2'b00;
    bus.ppfifo_size = '0;
    rst = 1'b1;
    repeat (2) tick();
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_act", 64'(bus.ppfifo_act), 64'd0);
    check("rst_stb", 64'(bus.ppfifo_stb), 64'd0);
    check("rst_data", 64'(bus.ppfifo_data), 64'd0);
    check("rst_space", 64'(bus.space), 64'd0);
    rst = 1'b0;
    ptr = 0;

    // single requester, 8-word buffer, data 0..7
    bus.ppfifo_rdy = 2'b11;
    bus.ppfifo_size = 24'd8;
    bus.req = 4'b0001;
    wr0 = n_writes;
    wait_grant(0, 8, cyc, ok);
    check("first_grant_latency", 64'(cyc), 64'd1);
    if (ok) run_packet(0, 8, 8, 0, 1'b1, iss);
    bus.req = '0;
    ptr = 1;
    check("single_writes", 64'(n_writes - wr0), 64'd8);

    // no ready half: requests wait
    bus.ppfifo_rdy = 2'b00;
    bus.req = 4'b1111;
    repeat (4) tick();
    check("nordy_gnt", 64'(bus.gnt), 64'd0);
    check("nordy_act", 64'(bus.ppfifo_act), 64'd0);
    bus.req = '0;
    tick();

    // upper half only, 10 strobes into a 4-word buffer
    bus.ppfifo_rdy = 2'b10;
    bus.ppfifo_size = 24'd4;
    bus.req = 4'b0001;
    wr0 = n_writes;
    wait_grant(0, 4, cyc, ok);
    if (ok) run_packet(0, 4, 10, 0, 1'b1, iss);
    bus.req = '0;
    ptr = 1;
    check("full_writes", 64'(n_writes - wr0), 64'd4);
    check("full_strobes_before_release", 64'(iss), 64'd5);

    // reset mid-packet returns the pointer to requester 0
    do_reset();
    bus.ppfifo_rdy = 2'b11;
    bus.ppfifo_size = 24'd2;
    bus.req = 4'b0011;
    wait_grant(0, 2, cyc, ok);
    if (ok) run_packet(0, 2, 2, 0, 1'b1, iss);
    bus.ppfifo_size = 24'd8;
    wait_grant(1, 8, cyc, ok);
    for (int i = 0; i < 3; i++) begin
      bus.stb = 4'b0010;
      bus.data[1*DW +: DW] = DW'(100 + i);
      exp_q.push_back(DW'(100 + i));
      tick();
    end
    bus.stb = '0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_gnt", 64'(bus.gnt), 64'd0);
    check("midrst_act", 64'(bus.ppfifo_act), 64'd0);
    check("midrst_stb", 64'(bus.ppfifo_stb), 64'd0);
    rst = 1'b0;
    ptr = 0;
    bus.ppfifo_size = 24'd3;
    wait_grant(0, 3, cyc, ok);
    if (ok) run_packet(0, 3, 1, 1, 1'b1, iss);
    bus.req[0] = 1'b0;
    ptr = 1;
    wait_grant(1, 3, cyc, ok);
    if (ok) run_packet(1, 3, 3, 0, 1'b1, iss);
    bus.req = '0;
    ptr = 2;

    for (int r = 0; r < 40; r++)
      run_round(NR'($urandom_range(1, (1 << NR) - 1)));
    run_round(4'b1111);

`ifdef PPFIFO_ARB_TIMEOUT_EN
    // silent grant released by the watchdog, next requester served
    do_reset();
    bus.ppfifo_rdy = 2'b01;
    bus.ppfifo_size = 24'd8;
    bus.req = 4'b0011;
    wait_grant(0, 8, cyc, ok);
    cyc = 0;
    while (bus.gnt != '0 && cyc < 60) begin
      tick();
      cyc++;
    end
    check("timeout_window", 64'(cyc >= TO && cyc <= TO + 2), 64'd1);
    bus.req[0] = 1'b0;
    wait_grant(1, 8, cyc, ok);
    bus.req = '0;
    cyc = 0;
    while (bus.gnt != '0 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("timeout_next_released", 64'(bus.gnt), 64'd0);
`endif

    bus.req = '0;
    repeat (3) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
